// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, counters, char-cell strobes; decode latency 1 pixel tick, pixEn stalls.
// Optional blink output when VGA_BLINK_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16
`ifdef VGA_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pixEn,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      videoOn,
  output logic [10:0]               hCount,
  output logic [10:0]               vCount,
  output logic                      colEn,
  output logic                      rowEn,
  output logic [$clog2(CHAR_W)-1:0] glyphCol,
  output logic [$clog2(CHAR_H)-1:0] glyphRow,
  output logic [6:0]                charCol,
  output logic [5:0]                charRow,
  output logic                      frameStart
`ifdef VGA_BLINK_EN
  ,
  output logic                      blink
`endif
);

  localparam int GCW = $clog2(CHAR_W);
  localparam int GRW = $clog2(CHAR_H);

  localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ACT   = HS_POL[0];
  localparam logic        VS_ACT   = VS_POL[0];

  logic [10:0]    h_q, h_d, v_q, v_d;
  logic           hs_q, hs_d, vs_q, vs_d;
  logic           vid_q, vid_d, row_q, row_d;
  logic           col_q, col_d, fs_q, fs_d;
  logic [GCW-1:0] gcol_q, gcol_d;
  logic [GRW-1:0] grow_q, grow_d;
  logic [6:0]     ccol_q, ccol_d;
  logic [5:0]     crow_q, crow_d;

  logic h_last, v_last, h_vis, v_vis, hs_act, vs_act;

  assign h_last = (h_q == H_TOTAL - 11'd1);
  assign v_last = (v_q == V_TOTAL - 11'd1);
  assign h_vis  = (h_q < H_VIS);
  assign v_vis  = (v_q < V_VIS);
  assign hs_act = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_act = (v_q >= VS_START) && (v_q < VS_END);

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    vid_d  = vid_q;
    row_d  = row_q;
    gcol_d = gcol_q;
    grow_d = grow_q;
    ccol_d = ccol_q;
    crow_d = crow_q;
    // Strobes only live for the single clock that follows a pixel tick.
    col_d  = 1'b0;
    fs_d   = 1'b0;
    if (pixEn) begin
      h_d = h_last ? 11'd0 : h_q + 11'd1;
      if (h_last) begin
        v_d = v_last ? 11'd0 : v_q + 11'd1;
      end
      // Flags describe the pixel at the pre-increment coordinates.
      hs_d   = hs_act ? HS_ACT : ~HS_ACT;
      vs_d   = vs_act ? VS_ACT : ~VS_ACT;
      vid_d  = h_vis && v_vis;
      row_d  = v_vis;
      gcol_d = h_q[GCW-1:0];
      grow_d = v_q[GRW-1:0];
      ccol_d = 7'(h_q >> GCW);
      crow_d = 6'(v_q >> GRW);
      col_d  = h_vis && v_vis && (h_q[GCW-1:0] == '0);
      fs_d   = (h_q == 11'd0) && (v_q == 11'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      hs_q   <= ~HS_ACT;
      vs_q   <= ~VS_ACT;
      vid_q  <= 1'b0;
      row_q  <= 1'b0;
      col_q  <= 1'b0;
      fs_q   <= 1'b0;
      gcol_q <= '0;
      grow_q <= '0;
      ccol_q <= '0;
      crow_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vid_q  <= vid_d;
      row_q  <= row_d;
      col_q  <= col_d;
      fs_q   <= fs_d;
      gcol_q <= gcol_d;
      grow_q <= grow_d;
      ccol_q <= ccol_d;
      crow_q <= crow_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign videoOn    = vid_q;
  assign rowEn      = row_q;
  assign colEn      = col_q;
  assign frameStart = fs_q;
  assign glyphCol   = gcol_q;
  assign glyphRow   = grow_q;
  assign charCol    = ccol_q;
  assign charRow    = crow_q;

`ifdef VGA_BLINK_EN
  logic [4:0] fcnt_q, fcnt_d;
  logic       blink_q, blink_d;

  // Counter advances on the clock after each frameStart strobe.
  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (fs_q) begin
      if (fcnt_q == 5'(BLINK_FRAMES - 1)) begin
        fcnt_d  = 5'd0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (96 x 41 ticks, 8 x 2 cells of 8x16).
module tb_vga_timing_gen;
  localparam int HT    = 96;
  localparam int VT    = 41;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset, pixEn;
  logic        hsync, vsync, videoOn, colEn, rowEn, frameStart;
  logic [10:0] hCount, vCount;
  logic [2:0]  glyphCol;
  logic [3:0]  glyphRow;
  logic [6:0]  charCol;
  logic [5:0]  charRow;
`ifdef VGA_BLINK_EN
  logic        blink;
`endif

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(32), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .HS_POL(0), .VS_POL(0), .CHAR_W(8), .CHAR_H(16)
`ifdef VGA_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clock(clock), .reset(reset), .pixEn(pixEn),
    .hsync(hsync), .vsync(vsync), .videoOn(videoOn),
    .hCount(hCount), .vCount(vCount), .colEn(colEn), .rowEn(rowEn),
    .glyphCol(glyphCol), .glyphRow(glyphRow), .charCol(charCol), .charRow(charRow),
    .frameStart(frameStart)
`ifdef VGA_BLINK_EN
    , .blink(blink)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_hcount"}, hCount, 0);
    check({pfx, "_vcount"}, vCount, 0);
    check({pfx, "_hsync"}, hsync, 1);
    check({pfx, "_vsync"}, vsync, 1);
    check({pfx, "_videoon"}, videoOn, 0);
    check({pfx, "_colen"}, colEn, 0);
    check({pfx, "_rowen"}, rowEn, 0);
    check({pfx, "_framestart"}, frameStart, 0);
    check({pfx, "_glyphcol"}, glyphCol, 0);
    check({pfx, "_glyphrow"}, glyphRow, 0);
    check({pfx, "_charcol"}, charCol, 0);
    check({pfx, "_charrow"}, charRow, 0);
  endtask

  initial begin
    int first_hs, first_vs, hs_low, hs_low_line0, vs_low, fs_cnt, col_cnt;
    int c0, c1, fs_seen, last_col, gap16, wide, hold_bad, idle_strobe, glyph_bad, wraps;
    int h_pre, v_pre, found;
    logic prev_col;

    // Reset held with pixEn high: reset must win.
    reset = 1'b1;
    pixEn = 1'b1;
    repeat (3) tick();
    check_reset_state("rst");
    reset = 1'b0;

    // Continuous pixEn over one full frame plus one tick.
    first_hs = 0; first_vs = 0; hs_low = 0; hs_low_line0 = 0; vs_low = 0; fs_cnt = 0; col_cnt = 0;
    for (int t = 1; t <= FRAME + 1; t++) begin
      tick();
      if (t == 1) begin
        check("first_tick_framestart", frameStart, 1);
        check("first_tick_colen", colEn, 1);
        check("first_tick_videoon", videoOn, 1);
        check("first_tick_hcount", hCount, 1);
      end
      if (t == 2) begin
        check("colen_one_clock", colEn, 0);
        check("framestart_one_clock", frameStart, 0);
      end
      if (t == HT) begin
        check("hwrap_hcount", hCount, 0);
        check("hwrap_vcount", vCount, 1);
        check("blank_pixel_rowen", rowEn, 1);
        check("blank_pixel_videoon", videoOn, 0);
      end
      if (t == 32 * HT + 1) begin
        check("blank_line_rowen", rowEn, 0);
        check("blank_line_videoon", videoOn, 0);
        check("blank_line_charcol", charCol, 0);
      end
      if (t == FRAME) begin
        check("frame_wrap_hcount", hCount, 0);
        check("frame_wrap_vcount", vCount, 0);
      end
      if (hsync == 1'b0) begin
        hs_low++;
        if (t <= HT) hs_low_line0++;
        if (first_hs == 0) first_hs = t;
      end
      if (vsync == 1'b0) begin
        vs_low++;
        if (first_vs == 0) first_vs = t;
      end
      if (t <= FRAME && frameStart) fs_cnt++;
      if (t <= FRAME && colEn) col_cnt++;
      if (t == FRAME + 1) check("second_framestart", frameStart, 1);
    end
    check("hsync_first_low_tick", first_hs, 73);
    check("hsync_width_line0", hs_low_line0, 16);
    check("hsync_low_per_frame", hs_low, 16 * VT);
    check("vsync_first_low_tick", first_vs, 35 * HT + 1);
    check("vsync_low_per_frame", vs_low, 2 * HT);
    check("framestart_per_frame", fs_cnt, 1);
    check("colen_per_frame_cont", col_cnt, 8 * 32);

    // pixEn on every other clock; measure one frame between frameStart strobes.
    c0 = 0; c1 = 0; fs_seen = 0; last_col = -1000; gap16 = 0; wide = 0;
    hold_bad = 0; idle_strobe = 0; glyph_bad = 0; wraps = 0; col_cnt = 0; prev_col = 1'b0;
    for (int c = 0; c < 5 * FRAME && fs_seen < 2; c++) begin
      pixEn = (c % 2 == 0);
      h_pre = int'(hCount);
      v_pre = int'(vCount);
      tick();
      if (!pixEn) begin
        if (hCount != 11'(h_pre) || vCount != 11'(v_pre)) hold_bad++;
        if (colEn || frameStart) idle_strobe++;
      end else begin
        if (int'(glyphRow) != v_pre % 16 || int'(glyphCol) != h_pre % 8 ||
            int'(charCol) != h_pre / 8 || int'(charRow) != v_pre / 16) glyph_bad++;
      end
      if (frameStart) begin
        fs_seen++;
        if (fs_seen == 1) c0 = c;
        if (fs_seen == 2) c1 = c;
      end
      if (fs_seen == 1) begin
        if (colEn) begin
          col_cnt++;
          if (c - last_col == 16) gap16++;
          last_col = c;
        end
        if (colEn && prev_col) wide++;
        if (pixEn && hCount == 11'd0 && h_pre != 0) wraps++;
      end
      prev_col = colEn;
    end
    pixEn = 1'b1;
    check("half_rate_frames_seen", fs_seen, 2);
    check("half_rate_frame_clocks", c1 - c0, 2 * FRAME);
    check("half_rate_line_wraps", wraps, VT);
    check("half_rate_colen_count", col_cnt, 8 * 32);
    check("half_rate_colen_spacing", gap16, 7 * 32);
    check("half_rate_colen_wide", wide, 0);
    check("idle_counter_hold", hold_bad, 0);
    check("idle_strobe_drop", idle_strobe, 0);
    check("glyph_char_index", glyph_bad, 0);

    // Reset mid-line while hsync is active.
    found = 0;
    for (int t = 0; t < 2 * FRAME && found == 0; t++) begin
      if (hCount == 11'd80 && vCount == 11'd20) found = 1;
      else tick();
    end
    check("reach_mid_hsync", found, 1);
    check("mid_hsync_low", hsync, 0);
    reset = 1'b1;
    tick();
    check_reset_state("midrst");
    reset = 1'b0;
    first_hs = 0;
    for (int t = 1; t <= HT && first_hs == 0; t++) begin
      tick();
      if (t == 1) check("restart_framestart", frameStart, 1);
      if (hsync == 1'b0) first_hs = t;
    end
    check("restart_hsync_first_low", first_hs, 73);

`ifdef VGA_BLINK_EN
    begin
      logic exp_b [4];
      int k;
      logic prev_fs;
      exp_b = '{1'b0, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("blink_reset", blink, 0);
      k = 0;
      prev_fs = 1'b0;
      for (int t = 0; t < 5 * FRAME && k < 4; t++) begin
        tick();
        if (prev_fs) begin
          check("blink_after_frame", blink, exp_b[k]);
          k++;
        end
        prev_fs = frameStart;
      end
      check("blink_frames_seen", k, 4);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
